traffic_field_controller: RTL and testbench

Parametrised successor to the single-block game controller: drives the player block plus NUM_LANES independently scrolling car lanes, and paints the playfield from the display controller's hCount/vCount raster. Adds per-lane speed and direction, pixel-accurate collision detection, and a lives/score game FSM (PLAY/HIT/OVER). Sits between the button debouncers and the VGA display controller. All motion advances only on a one-cycle frame `tick` from the pixel-clock domain.

---
 rtl/traffic_field_controller_if.sv | 22 ++
 rtl/traffic_field_controller.sv | 204 ++++++++++++++++++++
 tb/tb_traffic_field_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_field_controller_if.sv
// Controller-facing bundle: frame tick, raster position, buttons in; pixel colour and game status out.
interface traffic_field_controller_if;
  logic        tick;
  logic        bright;
  logic        up, down, left, right;
  logic [9:0]  hCount, vCount;
  logic [11:0] rgb;
  logic [9:0]  player_x, player_y;
  logic [3:0]  lives;
  logic [7:0]  score;
  logic        game_over;
  logic        hit;

  modport master (
    output tick, bright, up, down, left, right, hCount, vCount,
    input  rgb, player_x, player_y, lives, score, game_over, hit
  );
  modport slave (
    input  tick, bright, up, down, left, right, hCount, vCount,
    output rgb, player_x, player_y, lives, score, game_over, hit
  );
endinterface

// File: rtl/traffic_field_controller.sv
// Player block plus NUM_LANES scrolling car lanes: motion on frame tick, pixel collision,
// PLAY/HIT/OVER game FSM and combinational playfield painter.
module tfc_lane #(
  parameter logic [9:0] Y     = 10'd0,
  parameter logic [9:0] X0    = 10'd0,
  parameter logic [3:0] SPD   = 4'd1,
  parameter logic       DIR   = 1'b0,
  parameter int         HALF  = 34,
  parameter int         X_MIN = 150,
  parameter int         X_MAX = 800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic [9:0] h_i,
  input  logic [9:0] v_i,
  output logic       in_box_o
);
  localparam logic [10:0] SPD11  = {7'd0, SPD};
  localparam logic [10:0] HALF11 = 11'(HALF);
  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] Y11    = {1'b0, Y};

  logic [9:0]  x_q, x_d;
  logic [10:0] x11, fwd;

  always_comb begin
    x11 = {1'b0, x_q};
    fwd = x11 + SPD11;
    x_d = x_q;
    if (tick_i) begin
      if (DIR) x_d = (x11 < XMIN11 + SPD11) ? XMAX11[9:0] : 10'(x11 - SPD11);
      else     x_d = (fwd > XMAX11) ? XMIN11[9:0] : fwd[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) x_q <= X0;
    else      x_q <= x_d;
  end

  // Sum form keeps centre-half from underflowing near the field edge.
  assign in_box_o = (({1'b0, h_i} + HALF11) >= x11) && ({1'b0, h_i} <= x11 + HALF11) &&
                    (({1'b0, v_i} + HALF11) >= Y11) && ({1'b0, v_i} <= Y11 + HALF11);
endmodule

module traffic_field_controller #(
  parameter int                    NUM_LANES   = 4,
  parameter logic [NUM_LANES*10-1:0] LANE_Y    = {10'd450, 10'd320, 10'd250, 10'd130},
  parameter logic [NUM_LANES*10-1:0] LANE_X0   = {10'd450, 10'd600, 10'd450, 10'd450},
  parameter logic [NUM_LANES*4-1:0]  LANE_SPD  = {4'd8, 4'd2, 4'd6, 4'd4},
  parameter logic [NUM_LANES-1:0]    LANE_DIR  = 4'b0101,
  parameter logic [NUM_LANES*12-1:0] LANE_RGB  = {12'hFFF, 12'hFE8, 12'h08A, 12'hF0F},
  parameter int                    CAR_HALF    = 34,
  parameter int                    PLAYER_HALF = 30,
  parameter int                    X_MIN       = 150,
  parameter int                    X_MAX       = 800,
  parameter int                    Y_MAX       = 514,
  parameter int                    STEP        = 2,
  parameter int                    GOAL_Y      = 64,
  parameter int                    X0          = 450,
  parameter int                    Y0          = 484,
  parameter int                    LIVES       = 3,
  parameter int                    HIT_TICKS   = 32,
  parameter logic [11:0]           BG          = 12'h888,
  parameter logic [11:0]           PLAYER_RGB  = 12'hF00
) (
  input  logic clk,
  input  logic rst,
  traffic_field_controller_if.slave bus
);
  // Counter is at least 3 bits so the blink bit always exists.
  localparam int HW = ($clog2(HIT_TICKS) > 3) ? $clog2(HIT_TICKS) : 3;
  localparam logic [10:0] XLO  = 11'(X_MIN + PLAYER_HALF);
  localparam logic [10:0] XHI  = 11'(X_MAX - PLAYER_HALF);
  localparam logic [10:0] YHI  = 11'(Y_MAX - PLAYER_HALF);
  localparam logic [10:0] STP  = 11'(STEP);
  localparam logic [10:0] PH   = 11'(PLAYER_HALF);
  localparam logic [9:0]  X0_10   = 10'(X0);
  localparam logic [9:0]  Y0_10   = 10'(Y0);
  localparam logic [9:0]  GOAL_10 = 10'(GOAL_Y);
  localparam logic [3:0]  LIVES4  = 4'(LIVES);
  localparam logic [HW-1:0] HLAST = HW'(HIT_TICKS - 1);

  typedef enum logic [1:0] {S_PLAY, S_HIT, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [9:0]      px_q, px_d, py_q, py_d, px_mv, py_mv;
  logic [3:0]      lives_q, lives_d;
  logic [7:0]      score_q, score_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            hpend_q, hpend_d;
  logic [NUM_LANES-1:0] lane_in;
  logic [10:0]     px11, py11, h11, v11, rmv, lmv, umv, dmv;
  logic            p_in, det, hit_now, p_draw;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tfc_lane #(
      .Y(LANE_Y[g*10 +: 10]), .X0(LANE_X0[g*10 +: 10]), .SPD(LANE_SPD[g*4 +: 4]),
      .DIR(LANE_DIR[g]), .HALF(CAR_HALF), .X_MIN(X_MIN), .X_MAX(X_MAX)
    ) u_lane (
      .clk(clk), .rst(rst), .tick_i(bus.tick), .h_i(bus.hCount), .v_i(bus.vCount),
      .in_box_o(lane_in[g])
    );
  end

  always_comb begin
    px11 = {1'b0, px_q};
    py11 = {1'b0, py_q};
    h11  = {1'b0, bus.hCount};
    v11  = {1'b0, bus.vCount};
    p_in = ((h11 + PH) >= px11) && (h11 <= px11 + PH) &&
           ((v11 + PH) >= py11) && (v11 <= py11 + PH);
    det     = bus.bright && p_in && (|lane_in) && (state_q == S_PLAY);
    hit_now = hpend_q | det;
    rmv = px11 + STP;
    lmv = px11 - STP;
    umv = py11 - STP;
    dmv = py11 + STP;
    px_mv = px_q;
    py_mv = py_q;
    if (bus.right)     px_mv = (rmv > XHI) ? XHI[9:0] : rmv[9:0];
    else if (bus.left) px_mv = (px11 < XLO + STP) ? XLO[9:0] : lmv[9:0];
    else if (bus.up)   py_mv = umv[9:0];
    else if (bus.down) py_mv = (dmv > YHI) ? YHI[9:0] : dmv[9:0];
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    lives_d = lives_q;
    score_d = score_q;
    hcnt_d  = hcnt_q;
    hpend_d = bus.tick ? 1'b0 : hit_now;
    if (bus.tick) begin
      unique case (state_q)
        S_PLAY: begin
          px_d = px_mv;
          py_d = py_mv;
          if (hit_now) begin
            lives_d = lives_q - 4'd1;
            hcnt_d  = '0;
            state_d = S_HIT;
          end else if (py_mv <= GOAL_10) begin
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            px_d    = X0_10;
            py_d    = Y0_10;
          end
        end
        S_HIT: begin
          hcnt_d = hcnt_q + 1'b1;
          if (hcnt_q == HLAST) begin
            if (lives_q == 4'd0) state_d = S_OVER;
            else begin
              px_d    = X0_10;
              py_d    = Y0_10;
              state_d = S_PLAY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_PLAY;
      px_q    <= X0_10;
      py_q    <= Y0_10;
      lives_q <= LIVES4;
      score_q <= 8'd0;
      hcnt_q  <= '0;
      hpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      lives_q <= lives_d;
      score_q <= score_d;
      hcnt_q  <= hcnt_d;
      hpend_q <= hpend_d;
    end
  end

  // Player blinks during HIT; lower lane index wins where cars overlap.
  always_comb begin
    p_draw  = (state_q == S_PLAY) || ((state_q == S_HIT) && !hcnt_q[2]);
    bus.rgb = BG;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (lane_in[i]) bus.rgb = LANE_RGB[i*12 +: 12];
    if (p_draw && p_in) bus.rgb = PLAYER_RGB;
    if (!bus.bright) bus.rgb = 12'h000;
  end

  assign bus.player_x  = px_q;
  assign bus.player_y  = py_q;
  assign bus.lives     = lives_q;
  assign bus.score     = score_q;
  assign bus.game_over = (state_q == S_OVER);
  assign bus.hit       = (state_q == S_HIT);
endmodule

// File: tb/tb_traffic_field_controller.sv
// Directed bench: pixel table across lane positions, then movement, goal, hit and game-over sequences.
module tb_traffic_field_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  traffic_field_controller_if bus();
  traffic_field_controller dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int tk;
    int h;
    int v;
    bit br;
    int rgb;
  } vec_t;

  vec_t vt[$];
  int n_chk  = 0;
  int n_fail = 0;
  int tk     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic btn(input logic r, input logic l, input logic u, input logic d);
    bus.right = r; bus.left = l; bus.up = u; bus.down = d;
  endtask

  task automatic do_tick();
    @(negedge clk);
    bus.bright = 1'b0;
    bus.tick   = 1'b1;
    @(negedge clk);
    bus.tick   = 1'b0;
    tk++;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic tick_to(input int t);
    while (tk < t) do_tick();
  endtask

  task automatic pix(input int h, input int v, input bit b);
    @(negedge clk);
    bus.hCount = 10'(h);
    bus.vCount = 10'(v);
    bus.bright = b;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    btn(0, 0, 0, 0);
    bus.tick = 1'b0;
    bus.bright = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tk = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0; bus.bright = 1'b0; bus.hCount = '0; bus.vCount = '0;
    btn(0, 0, 0, 0);

    // {tick count, hCount, vCount, bright, expected rgb}
    vt.push_back('{0, 450, 484, 0, 'h000});
    vt.push_back('{0, 450, 500, 1, 'hF00});
    vt.push_back('{0, 450, 130, 1, 'hF0F});
    vt.push_back('{0, 416, 130, 1, 'hF0F});
    vt.push_back('{0, 415, 130, 1, 'h888});
    vt.push_back('{0, 484,  96, 1, 'hF0F});
    vt.push_back('{0, 485,  96, 1, 'h888});
    vt.push_back('{0, 450, 250, 1, 'h08A});
    vt.push_back('{0, 600, 320, 1, 'hFE8});
    vt.push_back('{0, 566, 354, 1, 'hFE8});
    vt.push_back('{0, 450, 420, 1, 'hFFF});
    vt.push_back('{0, 419, 500, 1, 'h888});
    vt.push_back('{0, 420, 514, 1, 'hF00});
    vt.push_back('{0, 420, 515, 1, 'h888});
    vt.push_back('{0, 481, 460, 1, 'hFFF});
    vt.push_back('{0,   0,   0, 1, 'h888});
    vt.push_back('{1, 412, 130, 1, 'hF0F});
    vt.push_back('{1, 411, 130, 1, 'h888});
    vt.push_back('{1, 490, 250, 1, 'h08A});
    vt.push_back('{1, 491, 250, 1, 'h888});
    vt.push_back('{1, 564, 320, 1, 'hFE8});
    vt.push_back('{1, 563, 320, 1, 'h888});
    vt.push_back('{1, 492, 420, 1, 'hFFF});
    vt.push_back('{1, 493, 420, 1, 'h888});
    vt.push_back('{43, 828, 420, 1, 'hFFF});
    vt.push_back('{43, 829, 420, 1, 'h888});
    vt.push_back('{44, 116, 420, 1, 'hFFF});
    vt.push_back('{44, 115, 420, 1, 'h888});
    vt.push_back('{44, 184, 420, 1, 'hFFF});
    vt.push_back('{58, 832, 250, 1, 'h08A});
    vt.push_back('{59, 116, 250, 1, 'h08A});
    vt.push_back('{59, 115, 250, 1, 'h888});
    vt.push_back('{75, 116, 130, 1, 'hF0F});
    vt.push_back('{75, 115, 130, 1, 'h888});
    vt.push_back('{76, 834, 130, 1, 'hF0F});
    vt.push_back('{76, 766, 130, 1, 'hF0F});
    vt.push_back('{76, 765, 130, 1, 'h888});
    vt.push_back('{76, 372, 420, 1, 'hFFF});
    vt.push_back('{76, 371, 420, 1, 'h888});

    // Reset state
    do_reset();
    chk("reset player_x", 32'(bus.player_x), 450);
    chk("reset player_y", 32'(bus.player_y), 484);
    chk("reset lives", 32'(bus.lives), 3);
    chk("reset score", 32'(bus.score), 0);
    chk("reset game_over", 32'(bus.game_over), 0);
    chk("reset hit", 32'(bus.hit), 0);

    // Lane motion and wrap, observed through the painter
    foreach (vt[i]) begin
      tick_to(vt[i].tk);
      pix(vt[i].h, vt[i].v, vt[i].br);
      chk($sformatf("vec%0d rgb (t%0d %0d,%0d)", i, vt[i].tk, vt[i].h, vt[i].v),
          32'(bus.rgb), 32'(vt[i].rgb));
    end
    chk("table no hit", 32'(bus.hit), 0);
    chk("table player_x", 32'(bus.player_x), 450);

    // Button priority and clamps
    do_reset();
    btn(1, 1, 1, 1);
    ticks(159);
    chk("right 159 ticks", 32'(bus.player_x), 768);
    do_tick();
    chk("right clamp", 32'(bus.player_x), 770);
    ticks(3);
    chk("right held at clamp", 32'(bus.player_x), 770);
    chk("right beats up/down", 32'(bus.player_y), 484);
    btn(0, 1, 1, 1);
    ticks(300);
    chk("left clamp", 32'(bus.player_x), 180);
    chk("left beats up", 32'(bus.player_y), 484);
    btn(0, 0, 1, 1);
    do_tick();
    chk("up beats down", 32'(bus.player_y), 482);
    btn(0, 0, 0, 1);
    ticks(5);
    chk("down clamp", 32'(bus.player_y), 484);

    // Goal reached
    do_reset();
    btn(0, 0, 1, 0);
    ticks(209);
    chk("goal approach y", 32'(bus.player_y), 66);
    chk("goal approach score", 32'(bus.score), 0);
    do_tick();
    chk("goal respawn y", 32'(bus.player_y), 484);
    chk("goal respawn x", 32'(bus.player_x), 450);
    chk("goal score", 32'(bus.score), 1);
    chk("goal no hit", 32'(bus.hit), 0);

    // Hit and goal on the same tick, then reset mid-HIT
    do_reset();
    ticks(117);
    btn(0, 0, 1, 0);
    ticks(209);
    chk("hitgoal approach y", 32'(bus.player_y), 66);
    pix(450, 96, 1);
    chk("hitgoal overlap rgb", 32'(bus.rgb), 'hF00);
    do_tick();
    chk("hitgoal hit", 32'(bus.hit), 1);
    chk("hitgoal lives", 32'(bus.lives), 2);
    chk("hitgoal score", 32'(bus.score), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midhit rst hit", 32'(bus.hit), 0);
    chk("midhit rst lives", 32'(bus.lives), 3);
    chk("midhit rst y", 32'(bus.player_y), 484);
    btn(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    tk = 0;

    // Three hits to game over
    do_reset();
    pix(450, 484, 1);
    chk("spawn overlap rgb", 32'(bus.rgb), 'hF00);
    do_tick();
    chk("hit1 hit", 32'(bus.hit), 1);
    chk("hit1 lives", 32'(bus.lives), 2);
    pix(450, 500, 1);
    chk("hit blink on", 32'(bus.rgb), 'hF00);
    btn(1, 0, 0, 0);
    ticks(4);
    chk("hit ignores buttons", 32'(bus.player_x), 450);
    pix(450, 500, 1);
    chk("hit blink off", 32'(bus.rgb), 'h888);
    btn(0, 0, 0, 0);
    tick_to(32);
    chk("hit1 still hit", 32'(bus.hit), 1);
    do_tick();
    chk("hit1 end hit", 32'(bus.hit), 0);
    chk("hit1 end x", 32'(bus.player_x), 450);
    chk("hit1 end y", 32'(bus.player_y), 484);
    tick_to(76);
    pix(430, 470, 1);
    do_tick();
    chk("hit2 lives", 32'(bus.lives), 1);
    tick_to(109);
    chk("hit2 end", 32'(bus.hit), 0);
    tick_to(158);
    pix(430, 470, 1);
    do_tick();
    chk("hit3 lives", 32'(bus.lives), 0);
    tick_to(191);
    chk("over game_over", 32'(bus.game_over), 1);
    chk("over hit", 32'(bus.hit), 0);
    btn(1, 0, 0, 0);
    do_tick();
    chk("over ignores buttons", 32'(bus.player_x), 450);
    pix(450, 500, 1);
    chk("over player hidden", 32'(bus.rgb), 'h888);
    pix(712, 420, 1);
    chk("over lanes move in", 32'(bus.rgb), 'hFFF);
    pix(713, 420, 1);
    chk("over lanes move out", 32'(bus.rgb), 'h888);
    do_reset();
    chk("over rst lives", 32'(bus.lives), 3);
    chk("over rst game_over", 32'(bus.game_over), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
